// File: rtl/rs_seq_pkg.sv
// rs_seq_pkg: shared encodings and defaults for the RS(204,188) frame sequencer.
// Imported by rs_byte_fifo and rs_frame_sequencer.
package rs_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_DEC = 2'd2,
    DRAIN    = 2'd3
  } seq_state_e;

  localparam int N_BYTES_DEF    = 204;
  localparam int K_BYTES_DEF    = 188;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int TIMEOUT_DEF    = 19008;

  localparam int ST_FAIL = 0;
  localparam int ST_PAR  = 1;
  localparam int ST_OVR  = 2;

endpackage

// File: rtl/rs_byte_fifo.sv
// rs_byte_fifo: receive FIFO, {parity, byte} entries.
// A pop frees a slot for a push in the same cycle even when full.
module rs_byte_fifo
  import rs_seq_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         drop_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         full, do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);
  assign drop_o  = push_i && !do_push;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/rs_frame_sequencer.sv
// rs_frame_sequencer: UART -> RS(204,188) decoder framing and output forwarding.
// Define RS_SEQ_TIMEOUT_EN to abort a stalled LOAD after TIMEOUT_CLKS idle clocks.
module rs_frame_sequencer
  import rs_seq_pkg::*;
#(
  parameter int N_BYTES    = N_BYTES_DEF,
  parameter int K_BYTES    = K_BYTES_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
`ifdef RS_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CLKS = TIMEOUT_DEF
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       rx_parity_err,
  output logic       dec_start,
  output logic [7:0] dec_data,
  output logic       dec_in_valid,
  input  logic       dec_ready,
  output logic       dec_abort,
  input  logic [7:0] dec_out_data,
  input  logic       dec_out_valid,
  input  logic       dec_fail,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_last,
  output logic [2:0] frame_status,
  output logic       frame_err,
  output logic       busy
);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Assert asynchronously, release two clocks after reset deasserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  seq_state_e state_q, state_d;
  logic [7:0] in_cnt_q, in_cnt_d;
  logic [7:0] out_cnt_q, out_cnt_d, out_cnt_n;
  logic       ovr_q, ovr_d, par_q, par_d;
  logic       fail_q, fail_d, fail_n;
  logic [7:0] out_data_q, out_data_d;
  logic       out_valid_q, out_valid_d;
  logic       out_last_q, out_last_d;
  logic [2:0] status_q, status_d;
  logic [8:0] head;
  logic       empty, drop, hs, fwd;
  logic       expire, flush;

  rs_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (9)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (rx_valid),
    .wdata_i ({rx_parity_err, rx_byte}),
    .pop_i   (hs),
    .rdata_o (head),
    .empty_o (empty),
    .drop_o  (drop)
  );

  assign dec_in_valid = !empty &&
                        (state_q == IDLE || state_q == LOAD);
  assign dec_data     = dec_in_valid ? head[7:0] : 8'h00;
  assign hs           = dec_in_valid && dec_ready;
  assign dec_start    = hs && (state_q == IDLE);
  assign fwd          = dec_out_valid &&
                        (state_q == WAIT_DEC || state_q == DRAIN);
  assign busy         = (state_q != IDLE) || !empty;

`ifdef RS_SEQ_TIMEOUT_EN
  logic [14:0] idle_q, idle_d;
  logic        abort_q;
  logic        stall;

  assign stall  = (state_q == LOAD) && !hs && !rx_valid;
  assign expire = stall && (idle_q == 15'(TIMEOUT_CLKS - 1));
  assign flush  = expire;

  always_comb begin
    idle_d = '0;
    if (stall) idle_d = idle_q + 15'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      abort_q <= expire;
    end
  end

  assign dec_abort = abort_q;
  assign frame_err = abort_q;
`else
  assign expire    = 1'b0;
  assign flush     = 1'b0;
  assign dec_abort = 1'b0;
  assign frame_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    ovr_d       = ovr_q | drop;
    par_d       = par_q | (hs & head[8]);
    fail_d      = fail_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    status_d    = 3'b000;
    out_cnt_n   = (state_q == WAIT_DEC) ? 8'd1 : out_cnt_q + 8'd1;
    fail_n      = (state_q == WAIT_DEC) ? dec_fail : fail_q;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          state_d  = LOAD;
          in_cnt_d = 8'd1;
        end
      end
      LOAD: begin
        if (expire) begin
          status_d[ST_OVR]  = ovr_q;
          status_d[ST_PAR]  = par_q;
          ovr_d    = 1'b0;
          par_d    = 1'b0;
          fail_d   = 1'b0;
          in_cnt_d = 8'd0;
          state_d  = IDLE;
        end else if (hs) begin
          in_cnt_d = in_cnt_q + 8'd1;
          if (in_cnt_q == 8'(N_BYTES - 1)) state_d = WAIT_DEC;
        end
      end
      WAIT_DEC, DRAIN: begin
        if (fwd) begin
          out_valid_d = 1'b1;
          out_data_d  = dec_out_data;
          fail_d      = fail_n;
          out_cnt_d   = out_cnt_n;
          state_d     = DRAIN;
          // Drops seen on the closing cycle belong to the next frame.
          if (out_cnt_n == 8'(K_BYTES)) begin
            out_last_d        = 1'b1;
            status_d[ST_OVR]  = ovr_q;
            status_d[ST_PAR]  = par_q;
            status_d[ST_FAIL] = fail_n;
            ovr_d     = drop;
            par_d     = 1'b0;
            fail_d    = 1'b0;
            in_cnt_d  = 8'd0;
            out_cnt_d = 8'd0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      ovr_q       <= 1'b0;
      par_q       <= 1'b0;
      fail_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      status_q    <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      ovr_q       <= ovr_d;
      par_q       <= par_d;
      fail_q      <= fail_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      status_q    <= status_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign frame_status = status_q;

endmodule

// File: doc/rs_frame_sequencer.md
Name: rs_frame_sequencer

Overview:
Sits between uart_reciever and the RS(204,188) decoder core; replaces the ad-hoc FSM_Reed glue. Buffers received bytes in a small FIFO and streams each 204-byte codeword into the decoder with start/valid/ready handshaking. Collects the 188 decoded bytes and forwards them with a last marker and per-frame status. Also handles parity errors, FIFO overrun and decoder failure.

Parameters:
N_BYTES, 204, codeword length in bytes
K_BYTES, 188, decoded payload bytes per frame
FIFO_DEPTH, 16, receive FIFO entries (power of 2)
TIMEOUT_CLKS, 19008, idle clocks in LOAD before abort (2 UART frames at 864 clk/bit × 11 bits)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_byte  in  8  byte from UART receiver
rx_valid  in  1  one-cycle strobe, rx_byte valid
rx_parity_err  in  1  parity error for current rx_byte, qualified by rx_valid
dec_start  out  1  one-cycle pulse, coincident with first dec_in_valid of a frame
dec_data  out  8  codeword byte to decoder
dec_in_valid  out  1  dec_data valid
dec_ready  in  1  decoder accepts byte when dec_in_valid && dec_ready
dec_abort  out  1  one-cycle pulse, decoder discards partial frame
dec_out_data  in  8  decoded byte
dec_out_valid  in  1  decoded byte strobe
dec_fail  in  1  uncorrectable codeword, sampled with first dec_out_valid
out_data  out  8  decoded payload byte
out_valid  out  1  out_data valid, one cycle per byte
out_last  out  1  high with 188th out_valid
frame_status  out  3  {overrun, parity_seen, dec_fail}, valid with out_last or frame_err
frame_err  out  1  one-cycle pulse on aborted frame
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, FIFO empty, counters 0, sticky flags cleared. Reset mid-frame discards everything; no dec_abort is issued (decoder is reset too).
- FIFO: push on rx_valid; pop when dec_in_valid && dec_ready. Push to a full FIFO drops the byte and sets sticky overrun. Simultaneous push/pop on full: pop first, push accepted. Each entry stores a parity bit; popping an entry with parity=1 sets sticky parity_seen.
- dec_data/dec_in_valid are driven combinationally from the FIFO head while state is LOAD (or IDLE with FIFO non-empty).
- States:
  - IDLE: when FIFO non-empty and dec_ready: pop, pulse dec_start, in_cnt=1, go to LOAD.
  - LOAD: pop on handshake, in_cnt++. When in_cnt reaches N_BYTES (after the 204th handshake), go to WAIT_DEC. Bytes arriving now or later stay queued for the next frame.
  - WAIT_DEC: on first dec_out_valid, latch dec_fail, forward the byte, out_cnt=1, go to DRAIN.
  - DRAIN: forward each dec_out_valid (out_data = dec_out_data registered, 1-cycle latency). The K_BYTES-th byte asserts out_last and frame_status. Then clear sticky flags and go to IDLE. Extra dec_out_valid in IDLE is ignored.
- The 1-cycle registered output applies to all forwarded bytes.
- in_cnt/out_cnt are 8 bits, never exceed N_BYTES/K_BYTES, and reset to 0 on return to IDLE.
- dec_fail does not abort the frame: all 188 bytes are still forwarded and status bit0 is set.

Optional Feature:
RS_SEQ_TIMEOUT_EN:
- Defined: a 15-bit idle counter runs in LOAD while no handshake occurs; it is cleared on any handshake or rx_valid (rx_valid wins over expiry in the same cycle). On reaching TIMEOUT_CLKS: pulse dec_abort and frame_err, present frame_status, flush the FIFO, clear flags, go to IDLE.
- Not defined: no counter; LOAD waits indefinitely; dec_abort and frame_err are tied 0.

Decomposition:
- Package rs_seq_pkg: state encoding localparams (IDLE, LOAD, WAIT_DEC, DRAIN), N_BYTES/K_BYTES defaults, frame_status bit indices.
- Sub-module rs_byte_fifo: 9-bit wide, FIFO_DEPTH, full/empty flags, push/pop with pop-first on full.

Test Plan:
- One clean codeword (204 bytes via UART, decoder always ready) -> one dec_start pulse, exactly 204 handshakes, 188 out_valid, out_last on the 188th, frame_status=000.
- Byte 10 has a parity error -> frame completes; frame_status=010 with out_last.
- dec_ready held low for 20 rx_valid strobes with FIFO_DEPTH=16 -> 4 bytes dropped, frame_status bit2=1; in_cnt still reaches 204 only after 4 further bytes.
- Decoder flags dec_fail on first output byte -> 188 bytes forwarded, frame_status=001, no frame_err.
- RS_SEQ_TIMEOUT_EN, stop after 100 bytes -> after 19008 idle clks: dec_abort and frame_err pulse, busy=0; next 204 bytes decode normally.
- Reset asserted in DRAIN at out_cnt=50 -> all outputs 0 immediately, state IDLE, no out_last.
